// File: rtl/vga_timing_gen.sv
// vga_timing_gen: two-axis VGA raster timing generator.
// Horizontal and vertical counters advance on pix_en. Sync, active, the
// visible-area coordinates and the line/frame strobes are decoded from the
// counter values being loaded on that same edge, so outputs carry no extra latency.
// Optional build macro VGA_TIMING_PREFETCH_EN adds fetch_valid/fetch_x/fetch_y.
// These outputs describe the pixel that the main outputs will show on the next pix_en.
module vga_timing_gen #(
    parameter int   H_VISIBLE  = 640,
    parameter int   H_FRONT    = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BACK     = 48,
    parameter int   V_VISIBLE  = 480,
    parameter int   V_FRONT    = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BACK     = 33,
    parameter logic H_SYNC_POL = 1'b0,
    parameter logic V_SYNC_POL = 1'b0,
    parameter int   CNT_W      = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pix_en,
    output logic             hsync,
    output logic             vsync,
    output logic             active,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start
`ifdef VGA_TIMING_PREFETCH_EN
    ,
    output logic             fetch_valid,
    output logic [CNT_W-1:0] fetch_x,
    output logic [CNT_W-1:0] fetch_y
`endif
);

    // Region boundaries. Each axis runs visible, front porch, sync, back porch.
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS_END    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS_END    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    // Raster position after one more pixel tick.
    function automatic logic [CNT_W-1:0] h_succ(input logic [CNT_W-1:0] h);
        return (h == H_LAST) ? '0 : h + CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] v_succ(input logic [CNT_W-1:0] h,
                                                input logic [CNT_W-1:0] v);
        if (h != H_LAST)
            return v;
        return (v == V_LAST) ? '0 : v + CNT_W'(1);
    endfunction

    function automatic logic in_visible(input logic [CNT_W-1:0] h,
                                        input logic [CNT_W-1:0] v);
        return (h < H_VIS_END) && (v < V_VIS_END);
    endfunction

    logic [CNT_W-1:0] h_cnt_reg, h_cnt_next;
    logic [CNT_W-1:0] v_cnt_reg, v_cnt_next;
    logic             hsync_reg, hsync_next;
    logic             vsync_reg, vsync_next;
    logic             active_reg, active_next;
    logic [CNT_W-1:0] x_reg, x_next;
    logic [CNT_W-1:0] y_reg, y_next;
    logic             line_start_reg, line_start_next;
    logic             frame_start_reg, frame_start_next;

    // Next raster position and its decode, used whenever pix_en is high.
    always_comb begin
        h_cnt_next       = h_succ(h_cnt_reg);
        v_cnt_next       = v_succ(h_cnt_reg, v_cnt_reg);
        active_next      = in_visible(h_cnt_next, v_cnt_next);
        x_next           = active_next ? h_cnt_next : '0;
        y_next           = active_next ? v_cnt_next : '0;
        hsync_next       = ((h_cnt_next >= H_SYNC_START) && (h_cnt_next < H_SYNC_END))
                           ? H_SYNC_POL : ~H_SYNC_POL;
        vsync_next       = ((v_cnt_next >= V_SYNC_START) && (v_cnt_next < V_SYNC_END))
                           ? V_SYNC_POL : ~V_SYNC_POL;
        line_start_next  = (h_cnt_next == '0);
        frame_start_next = (h_cnt_next == '0) && (v_cnt_next == '0);
    end

    // Counters and decoded outputs. Reset parks the counters on the last pixel,
    // so the first tick lands on (0,0). Strobes last one clock only.
    always_ff @(posedge clock) begin
        if (reset) begin
            h_cnt_reg       <= H_LAST;
            v_cnt_reg       <= V_LAST;
            hsync_reg       <= ~H_SYNC_POL;
            vsync_reg       <= ~V_SYNC_POL;
            active_reg      <= 1'b0;
            x_reg           <= '0;
            y_reg           <= '0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else if (pix_en) begin
            h_cnt_reg       <= h_cnt_next;
            v_cnt_reg       <= v_cnt_next;
            hsync_reg       <= hsync_next;
            vsync_reg       <= vsync_next;
            active_reg      <= active_next;
            x_reg           <= x_next;
            y_reg           <= y_next;
            line_start_reg  <= line_start_next;
            frame_start_reg <= frame_start_next;
        end else begin
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end
    end

    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign active      = active_reg;
    assign x           = x_reg;
    assign y           = y_reg;
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;

`ifdef VGA_TIMING_PREFETCH_EN
    logic [CNT_W-1:0] fetch_h_next, fetch_v_next;
    logic             fetch_valid_reg, fetch_valid_next;
    logic [CNT_W-1:0] fetch_x_reg, fetch_x_next;
    logic [CNT_W-1:0] fetch_y_reg, fetch_y_next;

    // Look one pixel beyond the position being loaded this tick.
    always_comb begin
        fetch_h_next     = h_succ(h_cnt_next);
        fetch_v_next     = v_succ(h_cnt_next, v_cnt_next);
        fetch_valid_next = in_visible(fetch_h_next, fetch_v_next);
        fetch_x_next     = fetch_valid_next ? fetch_h_next : '0;
        fetch_y_next     = fetch_valid_next ? fetch_v_next : '0;
    end

    // Prefetch outputs. Their reset value describes pixel (0,0), the first pixel shown.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_valid_reg <= 1'b1;
            fetch_x_reg     <= '0;
            fetch_y_reg     <= '0;
        end else if (pix_en) begin
            fetch_valid_reg <= fetch_valid_next;
            fetch_x_reg     <= fetch_x_next;
            fetch_y_reg     <= fetch_y_next;
        end
    end

    assign fetch_valid = fetch_valid_reg;
    assign fetch_x     = fetch_x_reg;
    assign fetch_y     = fetch_y_reg;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: drives two generators from shared stimulus.
// The first uses the default 640x480 timing. The second uses a tiny 7x5 raster
// with active-high sync pulses. The expected raster state comes from the number
// of pixel ticks seen since the last reset.
module tb_vga_timing_gen;

    logic clock = 1'b0;
    logic reset;
    logic pix_en;

    always #5 clock = ~clock;

    // default-timing instance
    logic        d_hsync, d_vsync, d_active, d_line_start, d_frame_start;
    logic [11:0] d_x, d_y;
    // small-raster instance
    logic        s_hsync, s_vsync, s_active, s_line_start, s_frame_start;
    logic [3:0]  s_x, s_y;
`ifdef VGA_TIMING_PREFETCH_EN
    logic        d_fetch_valid, s_fetch_valid;
    logic [11:0] d_fetch_x, d_fetch_y;
    logic [3:0]  s_fetch_x, s_fetch_y;
`endif

    vga_timing_gen u_dflt (
        .clock       (clock),
        .reset       (reset),
        .pix_en      (pix_en),
        .hsync       (d_hsync),
        .vsync       (d_vsync),
        .active      (d_active),
        .x           (d_x),
        .y           (d_y),
        .line_start  (d_line_start),
        .frame_start (d_frame_start)
`ifdef VGA_TIMING_PREFETCH_EN
        ,
        .fetch_valid (d_fetch_valid),
        .fetch_x     (d_fetch_x),
        .fetch_y     (d_fetch_y)
`endif
    );

    vga_timing_gen #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
        .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CNT_W(4)
    ) u_small (
        .clock       (clock),
        .reset       (reset),
        .pix_en      (pix_en),
        .hsync       (s_hsync),
        .vsync       (s_vsync),
        .active      (s_active),
        .x           (s_x),
        .y           (s_y),
        .line_start  (s_line_start),
        .frame_start (s_frame_start)
`ifdef VGA_TIMING_PREFETCH_EN
        ,
        .fetch_valid (s_fetch_valid),
        .fetch_x     (s_fetch_x),
        .fetch_y     (s_fetch_y)
`endif
    );

    typedef struct {
        logic        hs, vs, act, ls, fs, fv;
        logic [31:0] x, y, fx, fy;
    } exp_t;

    int     n_assert = 0;
    int     n_fail   = 0;
    longint ticks    = 0;   // pixel ticks since the last reset
    int     cyc      = 0;

    // Expected outputs for a raster: pixel p = ticks-1 sits at column p mod H_TOTAL
    // on line (p div H_TOTAL) mod V_TOTAL. The prefetch view describes pixel p+1.
    function automatic exp_t model(input int hv, hf, hs, hb, vv, vf, vs, vb,
                                   input logic hp, vp, input longint n, input logic ticked);
        exp_t e;
        int   ht, vt, h, v;
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
        if (n == 0) begin
            e.hs = ~hp; e.vs = ~vp; e.act = 1'b0;
            e.x = 0; e.y = 0; e.ls = 1'b0; e.fs = 1'b0;
        end else begin
            h = int'((n - 1) % ht);
            v = int'(((n - 1) / ht) % vt);
            e.act = (h < hv) && (v < vv);
            e.x   = e.act ? h : 0;
            e.y   = e.act ? v : 0;
            e.hs  = (h >= hv + hf && h < hv + hf + hs) ? hp : ~hp;
            e.vs  = (v >= vv + vf && v < vv + vf + vs) ? vp : ~vp;
            e.ls  = ticked && (h == 0);
            e.fs  = ticked && (h == 0) && (v == 0);
        end
        h = int'(n % ht);
        v = int'((n / ht) % vt);
        e.fv = (h < hv) && (v < vv);
        e.fx = e.fv ? h : 0;
        e.fy = e.fv ? v : 0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $display("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, expv);
            $error("%s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: apply inputs, let the edge happen, then compare both instances.
    task automatic step(input logic r, input logic pe);
        exp_t ed, es;
        logic ticked;
        reset  = r;
        pix_en = pe;
        @(posedge clock);
        #1;
        cyc++;
        ticked = !r && pe;
        if (r) ticks = 0;
        else if (pe) ticks++;
        ed = model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, ticks, ticked);
        es = model(4, 1, 1, 1, 2, 1, 1, 1, 1'b1, 1'b1, ticks, ticked);
        chk("D.hsync",       32'(d_hsync),       32'(ed.hs));
        chk("D.vsync",       32'(d_vsync),       32'(ed.vs));
        chk("D.active",      32'(d_active),      32'(ed.act));
        chk("D.x",           32'(d_x),           ed.x);
        chk("D.y",           32'(d_y),           ed.y);
        chk("D.line_start",  32'(d_line_start),  32'(ed.ls));
        chk("D.frame_start", 32'(d_frame_start), 32'(ed.fs));
        chk("S.hsync",       32'(s_hsync),       32'(es.hs));
        chk("S.vsync",       32'(s_vsync),       32'(es.vs));
        chk("S.active",      32'(s_active),      32'(es.act));
        chk("S.x",           32'(s_x),           es.x);
        chk("S.y",           32'(s_y),           es.y);
        chk("S.line_start",  32'(s_line_start),  32'(es.ls));
        chk("S.frame_start", 32'(s_frame_start), 32'(es.fs));
`ifdef VGA_TIMING_PREFETCH_EN
        chk("D.fetch_valid", 32'(d_fetch_valid), 32'(ed.fv));
        chk("D.fetch_x",     32'(d_fetch_x),     ed.fx);
        chk("D.fetch_y",     32'(d_fetch_y),     ed.fy);
        chk("S.fetch_valid", 32'(s_fetch_valid), 32'(es.fv));
        chk("S.fetch_x",     32'(s_fetch_x),     es.fx);
        chk("S.fetch_y",     32'(s_fetch_y),     es.fy);
`endif
    endtask

    initial begin
        reset  = 1'b1;
        pix_en = 1'b0;
        @(negedge clock);

        // reset state, then idle clocks after release hold it
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // continuous ticks: first pixel, end of visible area, line 0 sync, wrap to line 1
        for (int i = 0; i < 1700; i++) step(1'b0, 1'b1);

        // tick on every second clock: outputs hold and strobes stay one clock wide
        for (int i = 0; i < 600; i++) step(1'b0, i[0]);

        // reset for one clock mid-line, idle clock, then the first pixel again
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);

        // random tick pattern with occasional resets
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 399) == 0), ($urandom_range(0, 3) != 0));

        // a long continuous run to carry the default raster into its sync window again
        for (int i = 0; i < 900; i++) step(1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
